imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the core's instruction-fetch interface.
- Accepts word-fetch requests, looks up an internal word ROM/RAM and returns the instruction after a configurable number of wait states.
- Valid/ready handshake on both request and response channels.
- Side load port preloads the program image (bench or boot loader).

Parameters:
- DEPTH, 1024, number of 32-bit words stored (power of two)
- BASE, 32'h80000000, byte address of word 0; must match the core's PC reset value
- LATENCY, 2, wait-state cycles between request acceptance and response (0..15)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low (0 = reset)
- req_valid  input  1  fetch request valid
- req_ready  output  1  responder can accept a request
- req_addr  input  32  byte address of instruction
- resp_valid  output  1  response valid
- resp_ready  input  1  requester accepts response
- resp_data  output  32  instruction word
- resp_err  output  1  request misaligned or out of range
- ld_en  input  1  load-port write enable
- ld_addr  input  32  load-port byte address
- ld_data  input  32  load-port write data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, resp_valid=0, resp_data=0, resp_err=0, wait counter=0.
  - req_ready=1 (decoded from IDLE).
  - Memory contents are not reset.
  - Reset mid-transaction silently drops the pending request.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE; resp_valid=1 only in RESP.
- IDLE: on an edge with req_valid=1, latch req_addr (accept).
  - LATENCY=0: go to RESP.
  - LATENCY>0: go to WAIT with cnt=LATENCY-1.
- WAIT: each edge, if cnt==0 go to RESP, else decrement cnt.
- Latency: for a request accepted at edge e, resp_valid is high after edge e+LATENCY (LATENCY=0: the cycle immediately after acceptance).
- Read sampling:
  - resp_data/resp_err are registered on the edge that enters RESP.
  - They reflect memory content before any same-edge load write.
- RESP: resp_data/resp_err held stable while resp_valid=1 and resp_ready=0.
  - On an edge with resp_ready=1, go to IDLE and drop resp_valid.
  - resp_data keeps its last value.
- No back-to-back acceptance: peak throughput is one fetch per LATENCY+2 cycles.
- Address check, 32-bit unsigned: off = addr - BASE (wraps), idx = off >> 2.
  - err = (addr[1:0]!=0) | (idx >= DEPTH).
  - addr < BASE wraps to a large off and is an error.
  - addr = BASE+4*DEPTH-4 is the last legal word.
- On err: resp_err=1, resp_data=32'h0, memory not read.
- Load port: any state, any cycle. On an edge with ld_en=1 and a legal, aligned ld_addr, mem[idx]=ld_data. Illegal ld_addr is ignored, no error.
- req_addr changes while not accepted, or after acceptance, have no effect.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- Defined:
  - Adds output port perf_fetches (32 bits).
  - Increments by 1 on every completed response handshake (resp_valid & resp_ready), errors included.
  - Wraps 32'hFFFFFFFF to 0; reset to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset value: hold rst=0, then release -> req_ready=1, resp_valid=0, resp_data=0, resp_err=0.
- Basic fetch, LATENCY=2: load mem[0]=32'h00500093 via ld_addr=32'h80000000. Request addr 32'h80000000 accepted at edge e -> resp_valid high after edge e+2, resp_data=32'h00500093, resp_err=0.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout. Raise resp_ready -> IDLE next cycle, req_ready=1.
- Errors, each -> resp_err=1, resp_data=0:
  - addr 32'h80000002 (misaligned)
  - addr 32'h80001000 with DEPTH=1024 (out of range)
  - addr 32'h7FFFFFFC (below BASE, wraps)
- Last word and load race:
  - Load idx 1023 = 32'hDEADBEEF; fetch 32'h80000FFC -> 32'hDEADBEEF.
  - Issue ld_en to the same word on the edge entering RESP -> old value returned; the next fetch returns the new value.
- LATENCY=0 and mid-transaction reset:
  - Accept at edge e -> resp_valid high after edge e.
  - Assert rst during WAIT (LATENCY=3) -> resp_valid never rises; after release, req_ready=1.
  - With IMEM_PERF_CNT_EN, perf_fetches=0 after the reset.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves word fetches from an internal RAM after
// LATENCY wait states over valid/ready request and response channels, with a
// side load port for preloading the program image.
// Optional feature macro: IMEM_PERF_CNT_EN adds the perf_fetches output, a
// count of completed response handshakes.
// DEPTH is expected to be a power of two, at least 2. LATENCY is 0..15.
module imem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetches
`endif
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DepthW  = 32'(DEPTH);
  localparam logic [3:0]  CntInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic            enter_resp;

  logic [31:0]     mem [DEPTH];

  logic [31:0]     rd_addr, rd_woff, ld_woff;
  logic            rd_bad, ld_bad;
  logic [IdxW-1:0] rd_idx, ld_idx;

  // Address decode: word offset from BASE wraps, so addresses below BASE land far out of range.
  // In IDLE the live request address is used so LATENCY=0 can read on the accept edge.
  always_comb begin
    rd_addr = (state_q == StIdle) ? req_addr : addr_q;
    rd_woff = (rd_addr - BASE) >> 2;
    rd_bad  = (rd_addr[1:0] != 2'b00) || (rd_woff >= DepthW);
    rd_idx  = rd_woff[IdxW-1:0];
    ld_woff = (ld_addr - BASE) >> 2;
    ld_bad  = (ld_addr[1:0] != 2'b00) || (ld_woff >= DepthW);
    ld_idx  = ld_woff[IdxW-1:0];
  end

  // Next-state logic: accept in IDLE, count wait states, hold the response until taken.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Memory is sampled before any same-edge load write lands.
    if (enter_resp) begin
      state_d = StResp;
      err_d   = rd_bad;
      data_d  = rd_bad ? 32'h0 : mem[rd_idx];
    end
  end

  // Control and response registers; a reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Load port: legal aligned writes only, accepted in any state; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_bad) begin
      mem[ld_idx] <= ld_data;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_data  = data_q;
  assign resp_err   = err_q;

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] perf_q;

  // Count completed response handshakes, error responses included; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= 32'h0;
    end else if (resp_valid && resp_ready) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetches = perf_q;
`endif

endmodule
